// File: rtl/btn_input_stage.sv
// -----------------------------------------------------------------------------
// btn_input_stage
//
// Front end for the one-by-one operand loader. It synchronizes a bouncy push
// button and a 16-bit slide-switch word into the clk domain. It then debounces
// the button with a four-state FSM. On each qualified press it issues a single
// strobe and captures the switch word.
//
// Parameters
//   DEBOUNCE_CYCLES : number of consecutive stable synchronized samples that
//                     qualify a press or a release (2 .. 2^20)
//
// Ports
//   clk       in   1  system clock, all state updates on the rising edge
//   rst       in   1  synchronous, active-high reset
//   in_raw    in  16  raw slide-switch word, asynchronous to clk
//   btn_raw   in   1  raw push-button level, asynchronous and bouncy
//   data_out  out 16  switch word captured on the qualified press
//   btn_pulse out  1  one-cycle strobe per qualified press
//   held      out  1  high from a qualified press until a qualified release
// -----------------------------------------------------------------------------
module btn_input_stage #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] in_raw,
  input  logic        btn_raw,
  output logic [15:0] data_out,
  output logic        btn_pulse,
  output logic        held
);

  // Terminal count: a press or release qualifies when the counter reaches it
  // while the synchronized level is still stable.
  localparam logic [19:0] CNT_MAX = 20'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_CNT = 2'd1,
    HELD      = 2'd2,
    REL_CNT   = 2'd3
  } state_t;

  logic        btn_meta_q;
  logic        btn_s;
  logic [15:0] sw_meta_q;
  logic [15:0] sw_s;

  state_t      state_q;
  logic [19:0] cnt_q;
  logic [15:0] data_q;
  logic        btn_pulse_q;
  logic        held_q;

  // Two-flop synchronizers for the button and every switch bit
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_meta_q <= 1'b0;
      btn_s      <= 1'b0;
      sw_meta_q  <= 16'h0000;
      sw_s       <= 16'h0000;
    end else begin
      btn_meta_q <= btn_raw;
      btn_s      <= btn_meta_q;
      sw_meta_q  <= in_raw;
      sw_s       <= sw_meta_q;
    end
  end

  // Debounce FSM with registered strobe, capture register and held flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 20'd0;
      data_q      <= 16'h0000;
      btn_pulse_q <= 1'b0;
      held_q      <= 1'b0;
    end else begin
      // The strobe is high for exactly one cycle after the qualifying edge.
      btn_pulse_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (btn_s) begin
            state_q <= PRESS_CNT;
            cnt_q   <= 20'd0;
          end else begin
            state_q <= IDLE;
          end
        end
        PRESS_CNT: begin
          if (!btn_s) begin
            // Bounce during the press window: drop it silently.
            state_q <= IDLE;
          end else if (cnt_q == CNT_MAX) begin
            state_q     <= HELD;
            held_q      <= 1'b1;
            btn_pulse_q <= 1'b1;
            data_q      <= sw_s;
          end else begin
            cnt_q <= cnt_q + 20'd1;
          end
        end
        HELD: begin
          if (!btn_s) begin
            state_q <= REL_CNT;
            cnt_q   <= 20'd0;
          end else begin
            state_q <= HELD;
          end
        end
        REL_CNT: begin
          if (btn_s) begin
            // Release bounce: back to HELD, no new strobe.
            state_q <= HELD;
          end else if (cnt_q == CNT_MAX) begin
            state_q <= IDLE;
            held_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 20'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= 20'd0;
          held_q  <= 1'b0;
        end
      endcase
    end
  end

  assign data_out  = data_q;
  assign btn_pulse = btn_pulse_q;
  assign held      = held_q;

endmodule

// File: tb/tb_btn_input_stage.sv
module tb_btn_input_stage;

  logic        clk;
  logic        rst;
  logic [15:0] in_raw;
  logic        btn_raw;
  logic [15:0] data_out;
  logic        btn_pulse;
  logic        held;

  int tests;
  int fails;

  btn_input_stage #(.DEBOUNCE_CYCLES(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_raw   (in_raw),
    .btn_raw  (btn_raw),
    .data_out (data_out),
    .btn_pulse(btn_pulse),
    .held     (held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One rising edge, then settle 1 time unit before sampling or driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; btn_raw = 1'b0; in_raw = 16'h0000;
    for (int k = 0; k < 3; k++) step();
    tests++;
    if (btn_pulse !== 1'b0) begin fails++; $display("FAIL reset_pulse got=%b exp=0", btn_pulse); end
    tests++;
    if (held !== 1'b0) begin fails++; $display("FAIL reset_held got=%b exp=0", held); end
    tests++;
    if (data_out !== 16'h0000) begin fails++; $display("FAIL reset_data got=%h exp=0000", data_out); end
    rst = 1'b0;
    for (int k = 0; k < 4; k++) step();
  endtask

  // Clean press held 20 cycles: single pulse after the 7th edge.
  task automatic test_clean_press();
    int pulses;
    pulses = 0;
    in_raw = 16'd200; btn_raw = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (btn_pulse === 1'b1) pulses++;
      tests++;
      if (btn_pulse !== (k == 7)) begin
        fails++; $display("FAIL clean_pulse edge=%0d got=%b exp=%b", k, btn_pulse, (k == 7));
      end
      tests++;
      if (held !== (k >= 7)) begin
        fails++; $display("FAIL clean_held edge=%0d got=%b exp=%b", k, held, (k >= 7));
      end
      tests++;
      if (data_out !== ((k >= 7) ? 16'd200 : 16'd0)) begin
        fails++; $display("FAIL clean_data edge=%0d got=%0d", k, data_out);
      end
    end
    tests++;
    if (pulses != 1) begin fails++; $display("FAIL clean_count got=%0d exp=1", pulses); end
  endtask

  // Switch word changes while held: captured value must not move.
  task automatic test_data_hold();
    in_raw = 16'hFFFF;
    for (int k = 1; k <= 6; k++) begin
      step();
      tests++;
      if (data_out !== 16'd200 || btn_pulse !== 1'b0) begin
        fails++; $display("FAIL hold_data edge=%0d got=%0d/%b exp=200/0", k, data_out, btn_pulse);
      end
    end
  endtask

  // Low 2, high 5 stays held; then low 8 releases after the 7th edge.
  task automatic test_release_bounce();
    btn_raw = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      if (k == 3) btn_raw = 1'b1;
      step();
      tests++;
      if (held !== 1'b1 || btn_pulse !== 1'b0) begin
        fails++; $display("FAIL relb_held edge=%0d got=%b/%b exp=1/0", k, held, btn_pulse);
      end
    end
    btn_raw = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      tests++;
      if (held !== (k < 7) || btn_pulse !== 1'b0) begin
        fails++; $display("FAIL rel_held edge=%0d got=%b/%b exp=%b/0", k, held, btn_pulse, (k < 7));
      end
    end
    tests++;
    if (data_out !== 16'd200) begin fails++; $display("FAIL rel_data got=%0d exp=200", data_out); end
  endtask

  // Bouncy press pattern 1,1,0,0,1,1,0 then 0: no pulse at all.
  task automatic test_press_bounce();
    logic [6:0] pat;
    int pulses;
    pat = 7'b1100110;
    pulses = 0;
    in_raw = 16'h0ABC;
    for (int k = 0; k < 15; k++) begin
      btn_raw = (k < 7) ? pat[6 - k] : 1'b0;
      step();
      if (btn_pulse === 1'b1) pulses++;
      tests++;
      if (held !== 1'b0) begin fails++; $display("FAIL pb_held edge=%0d got=%b exp=0", k, held); end
    end
    tests++;
    if (pulses != 0) begin fails++; $display("FAIL pb_pulses got=%0d exp=0", pulses); end
    tests++;
    if (data_out !== 16'd200) begin fails++; $display("FAIL pb_data got=%0d exp=200", data_out); end
  endtask

  // One-cycle reset during PRESS_CNT with button kept high.
  task automatic test_reset_mid_press();
    int pulses;
    pulses = 0;
    in_raw = 16'h1234; btn_raw = 1'b1;
    for (int k = 1; k <= 4; k++) step();
    rst = 1'b1;
    step();
    tests++;
    if (btn_pulse !== 1'b0 || held !== 1'b0 || data_out !== 16'h0000) begin
      fails++; $display("FAIL rstmid_outs got=%b/%b/%h exp=0/0/0000", btn_pulse, held, data_out);
    end
    rst = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (btn_pulse === 1'b1) pulses++;
      tests++;
      if (btn_pulse !== (k == 7)) begin
        fails++; $display("FAIL rstmid_pulse edge=%0d got=%b exp=%b", k, btn_pulse, (k == 7));
      end
    end
    tests++;
    if (pulses != 1 || data_out !== 16'h1234) begin
      fails++; $display("FAIL rstmid_result got=%0d/%h exp=1/1234", pulses, data_out);
    end
    btn_raw = 1'b0;
    for (int k = 0; k < 10; k++) step();
  endtask

  // Six spaced presses with distinct operands.
  task automatic test_operand_sequence();
    logic [15:0] vals [6];
    int pulses;
    vals[0] = 16'd200; vals[1] = 16'd0; vals[2] = 16'd100;
    vals[3] = 16'd0;   vals[4] = 16'd0; vals[5] = 16'd1;
    for (int p = 0; p < 6; p++) begin
      pulses = 0;
      in_raw = vals[p]; btn_raw = 1'b1;
      for (int k = 1; k <= 10; k++) begin
        step();
        if (btn_pulse === 1'b1) pulses++;
        if (k == 7) begin
          tests++;
          if (btn_pulse !== 1'b1 || data_out !== vals[p]) begin
            fails++; $display("FAIL seq_press p=%0d got=%b/%0d exp=1/%0d", p, btn_pulse, data_out, vals[p]);
          end
        end
      end
      btn_raw = 1'b0;
      in_raw = 16'h5A5A;
      for (int k = 1; k <= 10; k++) begin
        step();
        if (btn_pulse === 1'b1) pulses++;
      end
      tests++;
      if (pulses != 1 || data_out !== vals[p] || held !== 1'b0) begin
        fails++; $display("FAIL seq_after p=%0d got=%0d/%0d/%b exp=1/%0d/0", p, pulses, data_out, held, vals[p]);
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1; btn_raw = 1'b0; in_raw = 16'h0000;
    #1;
    test_reset();
    test_clean_press();
    test_data_hold();
    test_release_bounce();
    test_press_bounce();
    test_reset_mid_press();
    test_operand_sequence();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/btn_input_stage.md
BTN_INPUT_STAGE -- requirements
Module: btn_input_stage

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, number of consecutive stable synchronized samples that qualify a press or a release; legal range 2..2^20.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_raw  input  16  raw slide-switch operand word, asynchronous to clk.
REQ-005 btn_raw  input  1  raw push-button level, asynchronous and bouncy.
REQ-006 data_out  output  16  switch word captured at the qualified press; feeds the one-by-one loader's 16-bit in port.
REQ-007 btn_pulse  output  1  one-cycle strobe per qualified press; feeds the loader's btn port.
REQ-008 held  output  1  high while a qualified press has not yet been qualified as released.

Function
REQ-009 btn_raw and each bit of in_raw SHALL pass through a 2-flop synchronizer; btn_s and sw_s denote the synchronizer outputs.
REQ-010 The FSM SHALL have exactly four states: IDLE, PRESS_CNT, HELD, REL_CNT; the counter SHALL be 20 bits wide.
REQ-011 IDLE: btn_s=1 -> PRESS_CNT with cnt=0; otherwise stay in IDLE.
REQ-012 PRESS_CNT: btn_s=0 -> IDLE (bounce rejected, no pulse); btn_s=1 and cnt<DEBOUNCE_CYCLES-1 -> cnt+1; btn_s=1 and cnt=DEBOUNCE_CYCLES-1 -> HELD.
REQ-013 On the PRESS_CNT->HELD edge the block SHALL register btn_pulse=1 and data_out<=sw_s; btn_pulse SHALL return to 0 on the next edge.
REQ-014 HELD: btn_s=0 -> REL_CNT with cnt=0; otherwise stay in HELD; btn_pulse SHALL never repeat while the button remains held.
REQ-015 REL_CNT: btn_s=1 -> HELD (release bounce, no pulse); btn_s=0 and cnt<DEBOUNCE_CYCLES-1 -> cnt+1; btn_s=0 and cnt=DEBOUNCE_CYCLES-1 -> IDLE.
REQ-016 held SHALL be 1 exactly when the state is HELD or REL_CNT.
REQ-017 Latency: with btn_raw stable high from clock edge E1, btn_pulse SHALL be high only in the cycle following edge E1+DEBOUNCE_CYCLES+2 (7th edge counting E1 as 1, for default 4).
REQ-018 data_out SHALL change only on a qualified-press edge and SHALL hold its value across in_raw changes, releases, and bounces.
REQ-019 Minimum press-to-press spacing SHALL be 2*DEBOUNCE_CYCLES+4 cycles; shorter activity SHALL produce at most one pulse.
REQ-020 btn_pulse and data_out SHALL be registered outputs with no combinational path from inputs.

Reset
REQ-021 While rst=1 at a rising edge: state<=IDLE, cnt<=0, synchronizer flops<=0, btn_pulse<=0, data_out<=16'h0000, held<=0.
REQ-022 Reset asserted during PRESS_CNT or HELD SHALL suppress any pending pulse and discard any partial count.
REQ-023 If btn_raw is high when rst deasserts, it SHALL be treated as a new press; one pulse follows per REQ-017, counting from the first edge with rst=0.

Verification
REQ-024 Clean press: in_raw=200, btn_raw=1 held 20 cycles -> exactly one btn_pulse, in the cycle after the 7th edge; data_out=200 from that cycle on; held=1.
REQ-025 Press bounce: btn_raw 1,1,0,0,1,1,0 (one value per cycle), then 0 -> no btn_pulse; held stays 0; data_out unchanged.
REQ-026 Release bounce: in HELD, btn_raw low 2 cycles then high 5 cycles -> no new pulse, held stays 1; then low 8 cycles -> held=0, state IDLE.
REQ-027 Data hold: after capture of 200, in_raw changed to 16'hFFFF while still held -> data_out remains 200 until the next qualified press.
REQ-028 Reset mid-press: rst=1 for 1 cycle during PRESS_CNT with btn_raw kept high -> all outputs 0 during reset; exactly one pulse after the 7th edge following rst deassertion.
REQ-029 Operand sequence: six spaced presses with in_raw=200,0,100,0,0,1 -> six single-cycle pulses; data_out shows 200,0,100,0,0,1 in that order.
